// File: rtl/pipe_queue.sv
// Circular FIFO between two pipeline stages with a valid/ready handshake on each side.
// The flag+value pointers tell full and empty apart and give the occupancy count.
module pipe_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [PTR_W:0]   count_o
);

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("pipe_queue: DEPTH must be a power of two and >= 2");
        end
        if (PTR_W != $clog2(DEPTH)) begin : g_bad_ptr_w
            $error("pipe_queue: PTR_W is derived from DEPTH and must not be overridden");
        end
    endgenerate

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W:0]   rd_ptr_reg, rd_ptr_next;
    logic [DEPTH-1:0] wr_sel;

    logic             wr_flag, rd_flag;
    logic [PTR_W-1:0] wr_value, rd_value;
    logic             empty, full;
    logic             enq, deq, do_enq;

    assign wr_flag  = wr_ptr_reg[PTR_W];
    assign rd_flag  = rd_ptr_reg[PTR_W];
    assign wr_value = wr_ptr_reg[PTR_W-1:0];
    assign rd_value = rd_ptr_reg[PTR_W-1:0];

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_value == rd_value) && (wr_flag != rd_flag);

    // Ready depends only on stored state, so a full queue cannot accept while dequeuing.
    assign in_ready_o  = !full;
    assign out_valid_o = !empty;
    assign out_data_o  = mem_reg[rd_value];
    assign count_o     = {wr_flag ^ rd_flag, wr_value} - {1'b0, rd_value};

    assign enq    = in_valid_i && in_ready_o;
    assign deq    = out_valid_o && out_ready_i;
    assign do_enq = enq && !flush_i && !reset;

    function automatic logic [PTR_W:0] ptr_inc(input logic [PTR_W:0] ptr);
        logic [PTR_W:0] res;
        if (ptr[PTR_W-1:0] == PTR_W'(DEPTH - 1)) begin
            res = {~ptr[PTR_W], {PTR_W{1'b0}}};
        end else begin
            res = {ptr[PTR_W], ptr[PTR_W-1:0] + PTR_W'(1)};
        end
        return res;
    endfunction

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (enq) begin
            wr_ptr_next = ptr_inc(wr_ptr_reg);
        end
        if (deq) begin
            rd_ptr_next = ptr_inc(rd_ptr_reg);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = do_enq && (wr_value == PTR_W'(gi));
        end
    endgenerate

    // Storage is deliberately left out of reset and flush; only the pointers are cleared.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_sel[i]) begin
                mem_reg[i] <= in_data_i;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

endmodule

// File: tb/tb_pipe_queue.sv
// Bench for pipe_queue: directed vector table for the corner cases, then random
// traffic checked against a queue-based model of the FIFO.
module tb_pipe_queue;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             flush_i = 1'b0;
    logic             in_valid_i = 1'b0;
    logic             in_ready_o;
    logic [WIDTH-1:0] in_data_i = '0;
    logic             out_valid_o;
    logic             out_ready_i = 1'b0;
    logic [WIDTH-1:0] out_data_o;
    logic [2:0]       count_o;

    int checks = 0;
    int failures = 0;

    pipe_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .count_o     (count_o)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        fl;
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        chk;
        logic        ev;
        logic        er;
        logic [2:0]  ec;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst, input logic fl, input logic iv,
                                input logic [31:0] din, input logic ordy, input logic chk,
                                input logic ev, input logic er, input logic [2:0] ec,
                                input logic [31:0] ed);
        vec_t v;
        v.rst = rst; v.fl = fl; v.iv = iv; v.din = din; v.ordy = ordy;
        v.chk = chk; v.ev = ev; v.er = er; v.ec = ec; v.ed = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic fl, input logic iv,
                         input logic [31:0] din, input logic ordy);
        reset = rst;
        flush_i = fl;
        in_valid_i = iv;
        in_data_i = din;
        out_ready_i = ordy;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Invariant monitor, sampled on the falling edge.
    logic        mon_en = 1'b0;
    logic        hold_prev = 1'b0;
    logic [31:0] data_prev = '0;
    always @(negedge clock) begin
        if (mon_en) begin
            check("count_le_depth", 32'(count_o <= 3'(DEPTH)), 32'd1);
            check("not_full_and_empty", 32'(!(!in_ready_o && !out_valid_o)), 32'd1);
            if (hold_prev) begin
                check("hold_valid", 32'(out_valid_o), 32'd1);
                check("hold_data", out_data_o, data_prev);
            end
            hold_prev = out_valid_o && !out_ready_i && !flush_i && !reset;
            data_prev = out_data_o;
        end
    end

    logic [31:0] model_q[$];

    initial begin
        vec_t v;
        logic r_rst, r_fl, r_iv, r_ordy, acc, dlv;
        logic [31:0] r_d;

        // Reset then idle.
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        // Fill to full, extra offer refused, head stable.
        vecs.push_back(mk(0, 0, 1, 32'hA0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'hA1, 0, 1, 1, 1, 1, 32'hA0));
        vecs.push_back(mk(0, 0, 1, 32'hA2, 0, 1, 1, 1, 2, 32'hA0));
        vecs.push_back(mk(0, 0, 1, 32'hA3, 0, 1, 1, 1, 3, 32'hA0));
        vecs.push_back(mk(0, 0, 1, 32'hA4, 0, 1, 1, 0, 4, 32'hA0));
        vecs.push_back(mk(0, 0, 1, 32'hA4, 0, 1, 1, 0, 4, 32'hA0));
        // Drain from full while offering 0xB0.
        vecs.push_back(mk(0, 0, 1, 32'hB0, 1, 1, 1, 0, 4, 32'hA0));
        vecs.push_back(mk(0, 0, 1, 32'hB0, 1, 1, 1, 1, 3, 32'hA1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 3, 32'hA2));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 2, 32'hA3));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 32'hB0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        // Stream 1..10, wrapping the pointers twice.
        for (int k = 1; k <= 10; k++) begin
            if (k == 1) vecs.push_back(mk(0, 0, 1, 32'(k), 1, 1, 0, 1, 0, 0));
            else        vecs.push_back(mk(0, 0, 1, 32'(k), 1, 1, 1, 1, 1, 32'(k - 1)));
        end
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 32'hA));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        // Flush with 3 entries while offering 0xFF and accepting.
        vecs.push_back(mk(0, 0, 1, 32'hC1, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'hC2, 0, 1, 1, 1, 1, 32'hC1));
        vecs.push_back(mk(0, 0, 1, 32'hC3, 0, 1, 1, 1, 2, 32'hC1));
        vecs.push_back(mk(0, 1, 1, 32'hFF, 1, 1, 1, 1, 3, 32'hC1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'hD0, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 32'hD0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        // Reset mid-stream with 2 entries, then reuse.
        vecs.push_back(mk(0, 0, 1, 32'hE1, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 32'hE2, 0, 1, 1, 1, 1, 32'hE1));
        vecs.push_back(mk(1, 0, 1, 32'hE3, 1, 1, 1, 1, 2, 32'hE1));
        vecs.push_back(mk(0, 0, 1, 32'h55, 0, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 1, 1, 1, 32'h55));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 0));

        drive(1, 0, 0, 0, 0);
        tick();
        mon_en = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.rst, v.fl, v.iv, v.din, v.ordy);
            if (v.chk) begin
                check($sformatf("vec%0d_valid", i), 32'(out_valid_o), 32'(v.ev));
                check($sformatf("vec%0d_ready", i), 32'(in_ready_o), 32'(v.er));
                check($sformatf("vec%0d_count", i), 32'(count_o), 32'(v.ec));
                if (v.ev) check($sformatf("vec%0d_data", i), out_data_o, v.ed);
            end
            $display("vec %0d: rst=%0d fl=%0d iv=%0d din=0x%0h ordy=%0d | valid=%0d ready=%0d count=%0d data=0x%0h",
                     i, v.rst, v.fl, v.iv, v.din, v.ordy, out_valid_o, in_ready_o, count_o, out_data_o);
            tick();
        end

        // Random traffic against a queue model; the table leaves the FIFO empty.
        model_q.delete();
        for (int c = 0; c < 400; c++) begin
            r_rst  = ($urandom_range(0, 99) < 2);
            r_fl   = ($urandom_range(0, 99) < 4);
            r_iv   = ($urandom_range(0, 99) < 70);
            r_ordy = ($urandom_range(0, 99) < 60);
            r_d    = $urandom;
            drive(r_rst, r_fl, r_iv, r_d, r_ordy);
            check("rnd_valid", 32'(out_valid_o), 32'(model_q.size() > 0));
            check("rnd_ready", 32'(in_ready_o), 32'(model_q.size() < DEPTH));
            check("rnd_count", 32'(count_o), 32'(model_q.size()));
            if (model_q.size() > 0) check("rnd_data", out_data_o, model_q[0]);
            $display("rnd %0d: rst=%0d fl=%0d iv=%0d din=0x%0h ordy=%0d | count=%0d data=0x%0h",
                     c, r_rst, r_fl, r_iv, r_d, r_ordy, count_o, out_data_o);
            tick();
            if (r_rst || r_fl) begin
                model_q.delete();
            end else begin
                acc = r_iv && (model_q.size() < DEPTH);
                dlv = r_ordy && (model_q.size() > 0);
                if (dlv) void'(model_q.pop_front());
                if (acc) model_q.push_back(r_d);
            end
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
